// File: rtl/boot_block_loader.sv
// boot_block_loader: boot-time copy of consecutive SD disk blocks into 512-bit memory lines.
// CPUs stay held in reset until every requested block has landed in memory.
module boot_block_loader #(
    parameter int unsigned LOAD_BASE = 0,
    parameter int unsigned LINE_AW   = 16,
    parameter bit          SWAP      = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               boot_en,
    input  logic [31:0]        block_addr,
    input  logic [31:0]        block_count,
    output logic               rd_req,
    output logic [31:0]        rd_blk,
    input  logic               rd_ack,
    input  logic               d_valid,
    input  logic [63:0]        d_data,
    output logic               d_ready,
    input  logic               rd_err,
    output logic               mem_wr_valid,
    output logic [LINE_AW-1:0] mem_wr_addr,
    output logic [511:0]       mem_wr_data,
    input  logic               mem_wr_ready,
    output logic               cpu_hold,
    output logic               boot_done,
    output logic               boot_fail
);
    typedef enum logic [2:0] {SAMPLE, IDLE_DONE, REQ, DATA, DRAIN, FAIL} state_t;

    state_t             state_q;
    logic [31:0]        cur_blk_q;
    logic [31:0]        remaining_q;
    logic [5:0]         word_q;
    logic [LINE_AW-1:0] line_cnt_q;
    logic [511:0]       line_q;
    logic [511:0]       stage_q;
    logic               stage_vld_q;
    logic               rd_req_q;
    logic               boot_done_q;
    logic               boot_fail_q;
    logic               cpu_hold_q;
    logic [63:0]        word_in;
    logic [511:0]       line_d;
    logic               xfer;
    logic               drain;

    always_comb begin
        word_in = d_data;
        if (SWAP)
            for (int i = 0; i < 8; i++) word_in[8*i +: 8] = d_data[8*(7-i) +: 8];
    end

    always_comb begin
        line_d = line_q;
        line_d[{word_q[2:0], 6'd0} +: 64] = word_in;
    end

    // The staging slot may be refilled in the same cycle memory takes the old line.
    assign d_ready      = (state_q == DATA) && (!stage_vld_q || mem_wr_ready);
    assign xfer         = d_valid && d_ready && !rd_err;
    assign drain        = stage_vld_q && mem_wr_ready;
    assign rd_req       = rd_req_q;
    assign rd_blk       = cur_blk_q;
    assign mem_wr_valid = stage_vld_q;
    assign mem_wr_addr  = LINE_AW'(LOAD_BASE) + line_cnt_q;
    assign mem_wr_data  = stage_q;
    assign cpu_hold     = cpu_hold_q;
    assign boot_done    = boot_done_q;
    assign boot_fail    = boot_fail_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SAMPLE;
            cur_blk_q   <= '0;
            remaining_q <= '0;
            word_q      <= '0;
            line_cnt_q  <= '0;
            line_q      <= '0;
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
            rd_req_q    <= 1'b0;
            boot_done_q <= 1'b0;
            boot_fail_q <= 1'b0;
            cpu_hold_q  <= 1'b1;
        end else begin
            if (drain) line_cnt_q <= line_cnt_q + 1'b1;
            if (xfer) begin
                line_q <= line_d;
                word_q <= word_q + 1'b1;
            end
            if (xfer && word_q[2:0] == 3'd7) begin
                stage_q     <= line_d;
                stage_vld_q <= 1'b1;
            end else if (drain) begin
                stage_vld_q <= 1'b0;
            end
            case (state_q)
                SAMPLE: begin
                    cur_blk_q   <= block_addr;
                    remaining_q <= block_count;
                    if (!boot_en || block_count == 32'd0) begin
                        state_q     <= IDLE_DONE;
                        boot_done_q <= 1'b1;
                        cpu_hold_q  <= 1'b0;
                    end else begin
                        state_q  <= REQ;
                        rd_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (rd_err) begin
                        state_q     <= FAIL;
                        rd_req_q    <= 1'b0;
                        boot_fail_q <= 1'b1;
                    end else if (rd_ack) begin
                        state_q  <= DATA;
                        rd_req_q <= 1'b0;
                        word_q   <= '0;
                    end
                end
                DATA: begin
                    if (rd_err) begin
                        state_q     <= FAIL;
                        boot_fail_q <= 1'b1;
                    end else if (xfer && word_q == 6'd63) begin
                        cur_blk_q   <= cur_blk_q + 1'b1;
                        remaining_q <= remaining_q - 1'b1;
                        state_q     <= (remaining_q == 32'd1) ? DRAIN : REQ;
                        rd_req_q    <= (remaining_q != 32'd1);
                    end
                end
                DRAIN: begin
                    if (!stage_vld_q) begin
                        state_q     <= IDLE_DONE;
                        boot_done_q <= 1'b1;
                        cpu_hold_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_boot_block_loader.sv
// tb_boot_block_loader: directed bench driving two loader instances (plain, and swapped with a wrapping base) in lockstep.
module tb_boot_block_loader;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         boot_en = 1'b0;
    logic [31:0]  block_addr = '0;
    logic [31:0]  block_count = '0;
    logic         rd_ack = 1'b0;
    logic         d_valid = 1'b0;
    logic [63:0]  d_data = '0;
    logic         rd_err = 1'b0;
    logic         mem_wr_ready = 1'b0;

    logic         rd_req_a, d_ready_a, mem_wr_valid_a, cpu_hold_a, boot_done_a, boot_fail_a;
    logic [31:0]  rd_blk_a;
    logic [15:0]  mem_wr_addr_a;
    logic [511:0] mem_wr_data_a;
    logic         rd_req_b, d_ready_b, mem_wr_valid_b, cpu_hold_b, boot_done_b, boot_fail_b;
    logic [31:0]  rd_blk_b;
    logic [15:0]  mem_wr_addr_b;
    logic [511:0] mem_wr_data_b;

    int checks = 0;
    int failures = 0;
    int g, blk_left, stall_cnt, dready_bad, lockstep_bad;
    bit sending;
    logic [15:0]  wa_addr[$];
    logic [511:0] wa_data[$];
    logic [15:0]  wb_addr[$];
    logic [511:0] wb_data[$];
    logic [31:0]  rblk[$];
    logic [31:0]  rblk_b[$];

    always #5 clk = ~clk;

    boot_block_loader u_a (
        .clk(clk), .reset(reset), .boot_en(boot_en), .block_addr(block_addr), .block_count(block_count),
        .rd_req(rd_req_a), .rd_blk(rd_blk_a), .rd_ack(rd_ack), .d_valid(d_valid), .d_data(d_data),
        .d_ready(d_ready_a), .rd_err(rd_err), .mem_wr_valid(mem_wr_valid_a), .mem_wr_addr(mem_wr_addr_a),
        .mem_wr_data(mem_wr_data_a), .mem_wr_ready(mem_wr_ready), .cpu_hold(cpu_hold_a),
        .boot_done(boot_done_a), .boot_fail(boot_fail_a)
    );

    boot_block_loader #(.LOAD_BASE(32'hFFFC), .LINE_AW(16), .SWAP(1'b1)) u_b (
        .clk(clk), .reset(reset), .boot_en(boot_en), .block_addr(block_addr), .block_count(block_count),
        .rd_req(rd_req_b), .rd_blk(rd_blk_b), .rd_ack(rd_ack), .d_valid(d_valid), .d_data(d_data),
        .d_ready(d_ready_b), .rd_err(rd_err), .mem_wr_valid(mem_wr_valid_b), .mem_wr_addr(mem_wr_addr_b),
        .mem_wr_data(mem_wr_data_b), .mem_wr_ready(mem_wr_ready), .cpu_hold(cpu_hold_b),
        .boot_done(boot_done_b), .boot_fail(boot_fail_b)
    );

    function automatic logic [63:0] sd_word(input int n);
        logic [31:0] u;
        u = n;
        return {16'hC0DE, u[15:0], ~u[15:0], 8'h5A, u[7:0]};
    endfunction

    function automatic logic [63:0] bswap(input logic [63:0] w);
        return {<<8{w}};
    endfunction

    function automatic logic [511:0] exp_line(input int l, input bit sw);
        logic [511:0] r;
        for (int k = 0; k < 8; k++) r[64*k +: 64] = sw ? bswap(sd_word(8*l + k)) : sd_word(8*l + k);
        return r;
    endfunction

    task automatic clear_model();
        g = 0; blk_left = 0; sending = 1'b0;
        stall_cnt = 0; dready_bad = 0; lockstep_bad = 0;
        wa_addr.delete(); wa_data.delete(); wb_addr.delete(); wb_data.delete();
        rblk.delete(); rblk_b.delete();
    endtask

    task automatic apply_reset(input bit en, input logic [31:0] addr, input logic [31:0] cnt);
        @(posedge clk); #1;
        reset = 1'b0; rd_ack = 1'b0; d_valid = 1'b0; rd_err = 1'b0; mem_wr_ready = 1'b0;
        boot_en = en; block_addr = addr; block_count = cnt;
        clear_model();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // SD controller and memory model; ready_pat 1 = memory accepts one cycle in three.
    task automatic run(input int ready_pat, input int err_at, input int budget, input bit expect_end);
        int cyc;
        bit fired;
        cyc = 0; fired = 1'b0;
        while (cyc < budget) begin
            mem_wr_ready = (ready_pat == 0) ? 1'b1 : (cyc % 3 == 2);
            rd_ack = rd_req_a;
            if (sending && !fired && err_at >= 0 && g == err_at) begin
                rd_err = 1'b1; d_valid = 1'b0; fired = 1'b1; sending = 1'b0;
            end else begin
                rd_err = 1'b0; d_valid = sending; d_data = sd_word(g);
            end
            #1;
            if (rd_req_b !== rd_req_a || d_ready_b !== d_ready_a || mem_wr_valid_b !== mem_wr_valid_a) lockstep_bad++;
            if (sending && mem_wr_valid_a && !mem_wr_ready) begin
                stall_cnt++;
                if (d_ready_a) dready_bad++;
            end
            if (mem_wr_valid_a && mem_wr_ready) begin wa_addr.push_back(mem_wr_addr_a); wa_data.push_back(mem_wr_data_a); end
            if (mem_wr_valid_b && mem_wr_ready) begin wb_addr.push_back(mem_wr_addr_b); wb_data.push_back(mem_wr_data_b); end
            if (d_valid && d_ready_a) begin
                g++; blk_left--;
                if (blk_left == 0) sending = 1'b0;
            end
            if (rd_req_a && rd_ack) begin
                rblk.push_back(rd_blk_a); rblk_b.push_back(rd_blk_b);
                sending = 1'b1; blk_left = 64;
            end
            @(posedge clk); #1;
            cyc++;
            if ((boot_done_a || boot_fail_a) && !mem_wr_valid_a) break;
        end
        rd_ack = 1'b0; d_valid = 1'b0; rd_err = 1'b0; mem_wr_ready = 1'b0;
        if (expect_end) begin
            checks++;
            if (!(boot_done_a || boot_fail_a)) begin
                failures++;
                $display("FAIL run_timeout got done=%b fail=%b exp end within %0d cycles", boot_done_a, boot_fail_a, budget);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rd_req_a !== 1'b0) begin failures++; $display("FAIL reset_rd_req got=%b exp=0", rd_req_a); end
        checks++; if (d_ready_a !== 1'b0) begin failures++; $display("FAIL reset_d_ready got=%b exp=0", d_ready_a); end
        checks++; if (mem_wr_valid_a !== 1'b0) begin failures++; $display("FAIL reset_mem_wr_valid got=%b exp=0", mem_wr_valid_a); end
        checks++; if (boot_done_a !== 1'b0) begin failures++; $display("FAIL reset_boot_done got=%b exp=0", boot_done_a); end
        checks++; if (boot_fail_a !== 1'b0) begin failures++; $display("FAIL reset_boot_fail got=%b exp=0", boot_fail_a); end
        checks++; if (cpu_hold_a !== 1'b1 || cpu_hold_b !== 1'b1) begin failures++; $display("FAIL reset_cpu_hold got=%b/%b exp=1", cpu_hold_a, cpu_hold_b); end
    endtask

    task automatic test_boot_disabled();
        int seen;
        apply_reset(1'b0, 32'h10, 32'd5);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (boot_done_a !== 1'b1) begin failures++; $display("FAIL dis_boot_done got=%b exp=1", boot_done_a); end
        checks++; if (cpu_hold_a !== 1'b0) begin failures++; $display("FAIL dis_cpu_hold got=%b exp=0", cpu_hold_a); end
        seen = 0;
        repeat (10) begin
            if (rd_req_a || d_ready_a || mem_wr_valid_a) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL dis_ports_idle got=%0d exp=0", seen); end
        apply_reset(1'b1, 32'h10, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (boot_done_a !== 1'b1 || rd_req_a !== 1'b0) begin failures++; $display("FAIL zero_count got done=%b req=%b exp done=1 req=0", boot_done_a, rd_req_a); end
    endtask

    task automatic test_single_block();
        apply_reset(1'b1, 32'h10, 32'd1);
        run(0, -1, 500, 1'b1);
        checks++; if (rblk.size() != 1) begin failures++; $display("FAIL single_req_count got=%0d exp=1", rblk.size()); end
        else begin checks++; if (rblk[0] !== 32'h10) begin failures++; $display("FAIL single_rd_blk got=%h exp=00000010", rblk[0]); end end
        checks++; if (wa_addr.size() != 8 || wb_addr.size() != 8) begin failures++; $display("FAIL single_writes got=%0d/%0d exp=8", wa_addr.size(), wb_addr.size()); end
        for (int i = 0; i < wa_addr.size(); i++) begin
            checks++;
            if (wa_addr[i] !== 16'(i) || wa_data[i] !== exp_line(i, 1'b0)) begin
                failures++; $display("FAIL single_line_a%0d got addr=%h data=%h exp addr=%h data=%h", i, wa_addr[i], wa_data[i], 16'(i), exp_line(i, 1'b0));
            end
        end
        for (int i = 0; i < wb_addr.size(); i++) begin
            checks++;
            if (wb_addr[i] !== 16'(32'hFFFC + i) || wb_data[i] !== exp_line(i, 1'b1)) begin
                failures++; $display("FAIL single_line_b%0d got addr=%h data=%h exp addr=%h data=%h", i, wb_addr[i], wb_data[i], 16'(32'hFFFC + i), exp_line(i, 1'b1));
            end
        end
        if (wa_data.size() > 0) begin
            checks++; if (wa_data[0][63:0] !== sd_word(0)) begin failures++; $display("FAIL single_word0 got=%h exp=%h", wa_data[0][63:0], sd_word(0)); end
        end
        checks++; if (boot_done_a !== 1'b1 || cpu_hold_a !== 1'b0 || boot_fail_a !== 1'b0) begin failures++; $display("FAIL single_status got done=%b hold=%b fail=%b exp 1 0 0", boot_done_a, cpu_hold_a, boot_fail_a); end
        checks++; if (boot_done_b !== 1'b1 || cpu_hold_b !== 1'b0) begin failures++; $display("FAIL single_status_b got done=%b hold=%b exp 1 0", boot_done_b, cpu_hold_b); end
    endtask

    task automatic test_back_to_back_backpressure();
        apply_reset(1'b1, 32'h10, 32'd3);
        run(1, -1, 3000, 1'b1);
        checks++; if (rblk.size() != 3) begin failures++; $display("FAIL bp_req_count got=%0d exp=3", rblk.size()); end
        for (int i = 0; i < rblk.size(); i++) begin
            checks++; if (rblk[i] !== 32'h10 + 32'(i)) begin failures++; $display("FAIL bp_rd_blk%0d got=%h exp=%h", i, rblk[i], 32'h10 + 32'(i)); end
        end
        checks++; if (wa_addr.size() != 24 || wb_addr.size() != 24) begin failures++; $display("FAIL bp_writes got=%0d/%0d exp=24", wa_addr.size(), wb_addr.size()); end
        for (int i = 0; i < wa_addr.size(); i++) begin
            checks++;
            if (wa_addr[i] !== 16'(i) || wa_data[i] !== exp_line(i, 1'b0)) begin
                failures++; $display("FAIL bp_line_a%0d got addr=%h data=%h exp addr=%h data=%h", i, wa_addr[i], wa_data[i], 16'(i), exp_line(i, 1'b0));
            end
        end
        for (int i = 0; i < wb_addr.size(); i++) begin
            checks++;
            if (wb_addr[i] !== 16'(32'hFFFC + i) || wb_data[i] !== exp_line(i, 1'b1)) begin
                failures++; $display("FAIL bp_line_b%0d got addr=%h data=%h exp addr=%h data=%h", i, wb_addr[i], wb_data[i], 16'(32'hFFFC + i), exp_line(i, 1'b1));
            end
        end
        checks++; if (stall_cnt == 0 || dready_bad != 0) begin failures++; $display("FAIL bp_d_ready_stall got stalls=%0d ready_while_full=%0d exp stalls>0 ready_while_full=0", stall_cnt, dready_bad); end
        checks++; if (lockstep_bad != 0) begin failures++; $display("FAIL bp_lockstep got=%0d exp=0", lockstep_bad); end
        checks++; if (g != 192) begin failures++; $display("FAIL bp_words got=%0d exp=192", g); end
        checks++; if (boot_done_a !== 1'b1 || cpu_hold_a !== 1'b0) begin failures++; $display("FAIL bp_status got done=%b hold=%b exp 1 0", boot_done_a, cpu_hold_a); end
    endtask

    task automatic test_rd_err();
        int late;
        apply_reset(1'b1, 32'h10, 32'd3);
        run(1, 85, 3000, 1'b1);
        checks++; if (wa_addr.size() != 10) begin failures++; $display("FAIL err_writes got=%0d exp=10", wa_addr.size()); end
        for (int i = 0; i < wa_addr.size(); i++) begin
            checks++;
            if (wa_addr[i] !== 16'(i) || wa_data[i] !== exp_line(i, 1'b0)) begin
                failures++; $display("FAIL err_line%0d got addr=%h data=%h exp addr=%h data=%h", i, wa_addr[i], wa_data[i], 16'(i), exp_line(i, 1'b0));
            end
        end
        checks++; if (rblk.size() != 2) begin failures++; $display("FAIL err_req_count got=%0d exp=2", rblk.size()); end
        checks++; if (boot_fail_a !== 1'b1 || boot_fail_b !== 1'b1) begin failures++; $display("FAIL err_boot_fail got=%b/%b exp=1", boot_fail_a, boot_fail_b); end
        checks++; if (cpu_hold_a !== 1'b1 || boot_done_a !== 1'b0) begin failures++; $display("FAIL err_hold got hold=%b done=%b exp hold=1 done=0", cpu_hold_a, boot_done_a); end
        mem_wr_ready = 1'b1;
        d_valid = 1'b1;
        late = 0;
        repeat (8) begin
            #1;
            if (mem_wr_valid_a || rd_req_a || d_ready_a) late++;
            @(posedge clk); #1;
        end
        d_valid = 1'b0; mem_wr_ready = 1'b0;
        checks++; if (late != 0) begin failures++; $display("FAIL err_terminal got=%0d exp=0", late); end
    endtask

    task automatic test_reset_restart();
        apply_reset(1'b1, 32'h40, 32'd3);
        run(0, -1, 40, 1'b0);
        checks++; if (wa_addr.size() == 0 || rblk.size() != 1) begin failures++; $display("FAIL rst_partial got writes=%0d reqs=%0d exp writes>0 reqs=1", wa_addr.size(), rblk.size()); end
        @(posedge clk); #1;
        mem_wr_ready = 1'b1;
        reset = 1'b0;
        #1;
        checks++; if (mem_wr_valid_a !== 1'b0 || rd_req_a !== 1'b0 || d_ready_a !== 1'b0 || cpu_hold_a !== 1'b1) begin
            failures++; $display("FAIL rst_abort got valid=%b req=%b ready=%b hold=%b exp 0 0 0 1", mem_wr_valid_a, rd_req_a, d_ready_a, cpu_hold_a);
        end
        apply_reset(1'b1, 32'h20, 32'd2);
        run(0, -1, 800, 1'b1);
        checks++; if (rblk.size() != 2 || (rblk.size() == 2 && (rblk[0] !== 32'h20 || rblk[1] !== 32'h21))) begin
            failures++; $display("FAIL rst_rd_blk got n=%0d exp 00000020,00000021", rblk.size());
        end
        checks++; if (wa_addr.size() != 16) begin failures++; $display("FAIL rst_writes got=%0d exp=16", wa_addr.size()); end
        for (int i = 0; i < wa_addr.size(); i++) begin
            checks++;
            if (wa_addr[i] !== 16'(i) || wa_data[i] !== exp_line(i, 1'b0)) begin
                failures++; $display("FAIL rst_line%0d got addr=%h data=%h exp addr=%h data=%h", i, wa_addr[i], wa_data[i], 16'(i), exp_line(i, 1'b0));
            end
        end
        checks++; if (boot_done_a !== 1'b1) begin failures++; $display("FAIL rst_done got=%b exp=1", boot_done_a); end
    endtask

    task automatic test_wrap();
        apply_reset(1'b1, 32'hFFFF_FFFF, 32'd2);
        run(0, -1, 800, 1'b1);
        checks++; if (rblk.size() != 2) begin failures++; $display("FAIL wrap_req_count got=%0d exp=2", rblk.size()); end
        else begin
            checks++; if (rblk[0] !== 32'hFFFF_FFFF || rblk_b[0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_rd_blk0 got=%h/%h exp=ffffffff", rblk[0], rblk_b[0]); end
            checks++; if (rblk[1] !== 32'h0 || rblk_b[1] !== 32'h0) begin failures++; $display("FAIL wrap_rd_blk1 got=%h/%h exp=00000000", rblk[1], rblk_b[1]); end
        end
        checks++; if (wb_addr.size() != 16) begin failures++; $display("FAIL wrap_writes got=%0d exp=16", wb_addr.size()); end
        else begin
            checks++; if (wb_addr[3] !== 16'hFFFF || wb_addr[4] !== 16'h0000) begin failures++; $display("FAIL wrap_addr got=%h,%h exp=ffff,0000", wb_addr[3], wb_addr[4]); end
        end
        for (int i = 0; i < wb_addr.size(); i++) begin
            checks++;
            if (wb_addr[i] !== 16'(32'hFFFC + i) || wb_data[i] !== exp_line(i, 1'b1)) begin
                failures++; $display("FAIL wrap_line%0d got addr=%h data=%h exp addr=%h data=%h", i, wb_addr[i], wb_data[i], 16'(32'hFFFC + i), exp_line(i, 1'b1));
            end
        end
        checks++; if (boot_done_b !== 1'b1) begin failures++; $display("FAIL wrap_done got=%b exp=1", boot_done_b); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        test_reset();
        test_boot_disabled();
        test_single_block();
        test_back_to_back_backpressure();
        test_rd_err();
        test_reset_restart();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
